// File: rtl/ie_branch_unit.sv
// 6502 branch/jump resolver for the IE stage.
// Applies taken/page-cross penalties and fetches indirect JMP pointers.
module ie_branch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [7:0]  op_code,
  input  logic        jmp_indirect,
  input  logic [7:0]  status,
  input  logic [15:0] pc,
  input  logic [15:0] operand,
  output logic        mem_rd_req,
  output logic [15:0] mem_addr,
  input  logic        mem_rd_valid,
  input  logic [7:0]  mem_rd_data,
  output logic        done,
  output logic        pc_load,
  output logic [15:0] pc_out,
  output logic        taken,
  output logic        illegal
);

  localparam logic [7:0] OP_BCC = 8'h04;
  localparam logic [7:0] OP_BCS = 8'h05;
  localparam logic [7:0] OP_BEQ = 8'h06;
  localparam logic [7:0] OP_BMI = 8'h07;
  localparam logic [7:0] OP_BNE = 8'h08;
  localparam logic [7:0] OP_BPL = 8'h09;
  localparam logic [7:0] OP_BVC = 8'h0A;
  localparam logic [7:0] OP_BVS = 8'h0B;
  localparam logic [7:0] OP_JMP = 8'h1C;

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_TAKEN, S_FIX,
    S_PTR_LO, S_PTR_HI, S_COMPLETE
  } state_t;

  state_t      state, nxt;
  logic [7:0]  code_q, stat_q, lo_q;
  logic        ind_q, tk_q, ill_q;
  logic [15:0] pc_q, opnd_q, tgt_q, pc_out_q;
  logic [15:0] br_tgt, res;
  logic        is_br, is_jmp, cond;

  assign is_jmp = (code_q == OP_JMP);
  assign br_tgt = pc_q + {{8{opnd_q[7]}}, opnd_q[7:0]};

  always_comb begin
    is_br = 1'b1;
    cond  = 1'b0;
    case (code_q)
      OP_BCC:  cond = !stat_q[0];
      OP_BCS:  cond =  stat_q[0];
      OP_BEQ:  cond =  stat_q[1];
      OP_BMI:  cond =  stat_q[7];
      OP_BNE:  cond = !stat_q[1];
      OP_BPL:  cond = !stat_q[7];
      OP_BVC:  cond = !stat_q[6];
      OP_BVS:  cond =  stat_q[6];
      default: is_br = 1'b0;
    endcase
  end

  always_comb begin
    nxt        = state;
    op_ready   = 1'b0;
    mem_rd_req = 1'b0;
    mem_addr   = 16'h0000;
    res        = pc_q;
    unique case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) nxt = S_EVAL;
      end
      S_EVAL: begin
        if (is_br) begin
          nxt = cond ? S_TAKEN : S_COMPLETE;
        end else if (is_jmp) begin
          res = opnd_q;
          nxt = ind_q ? S_PTR_LO : S_COMPLETE;
        end else begin
          nxt = S_COMPLETE;
        end
      end
      S_TAKEN: begin
        res = tgt_q;
        nxt = (tgt_q[15:8] != pc_q[15:8]) ? S_FIX : S_COMPLETE;
      end
      S_FIX: begin
        res = tgt_q;
        nxt = S_COMPLETE;
      end
      S_PTR_LO: begin
        mem_rd_req = 1'b1;
        mem_addr   = opnd_q;
        if (mem_rd_valid) nxt = S_PTR_HI;
      end
      // high byte read never carries into the page
      S_PTR_HI: begin
        mem_rd_req = 1'b1;
        mem_addr   = {opnd_q[15:8], opnd_q[7:0] + 8'd1};
        res        = {mem_rd_data, lo_q};
        if (mem_rd_valid) nxt = S_COMPLETE;
      end
      S_COMPLETE: nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      code_q   <= 8'h00;
      stat_q   <= 8'h00;
      ind_q    <= 1'b0;
      pc_q     <= 16'h0000;
      opnd_q   <= 16'h0000;
      tgt_q    <= 16'h0000;
      tk_q     <= 1'b0;
      ill_q    <= 1'b0;
      lo_q     <= 8'h00;
      pc_out_q <= 16'h0000;
    end else begin
      state <= nxt;
      if (state == S_IDLE && op_valid) begin
        code_q <= op_code;
        stat_q <= status;
        ind_q  <= jmp_indirect;
        pc_q   <= pc;
        opnd_q <= operand;
      end
      if (state == S_EVAL) begin
        tgt_q <= br_tgt;
        tk_q  <= is_jmp | (is_br & cond);
        ill_q <= !is_br & !is_jmp;
      end
      if (state == S_PTR_LO && mem_rd_valid) lo_q <= mem_rd_data;
      if (nxt == S_COMPLETE) pc_out_q <= res;
    end
  end

  assign done    = (state == S_COMPLETE);
  assign taken   = done & tk_q;
  assign pc_load = taken;
  assign illegal = done & ill_q;
  assign pc_out  = pc_out_q;

endmodule

// File: tb/tb_ie_branch_unit.sv
// Directed bench for ie_branch_unit: latency, targets, condition sweep,
// indirect pointer fetch and mid-read reset.
module tb_ie_branch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [7:0]  op_code = 8'h00;
  logic        jmp_indirect = 1'b0;
  logic [7:0]  status = 8'h00;
  logic [15:0] pc = 16'h0000;
  logic [15:0] operand = 16'h0000;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        mem_rd_valid = 1'b0;
  logic [7:0]  mem_rd_data = 8'h00;
  logic        done, pc_load, taken, illegal;
  logic [15:0] pc_out;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int acc    = 0;
  int lat    = 0;
  int prev_acc = 0;

  ie_branch_unit dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .jmp_indirect(jmp_indirect),
    .status(status), .pc(pc), .operand(operand),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .done(done), .pc_load(pc_load), .pc_out(pc_out),
    .taken(taken), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [7:0] c, input logic ind,
                       input logic [7:0] st, input logic [15:0] p,
                       input logic [15:0] o);
    int n = 0;
    while (!op_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    op_code = c; jmp_indirect = ind; status = st;
    pc = p; operand = o; op_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    op_valid = 1'b0; op_code = 8'h1C; jmp_indirect = ~ind;
    status = ~st; pc = 16'hDEAD; operand = 16'hBEEF;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_done"}, done, 1'b1);
    lat = cyc - acc + 1;
  endtask

  task automatic run(input string tag, input logic [7:0] c,
                     input logic [7:0] st, input logic [15:0] p,
                     input logic [15:0] o, input int elat,
                     input logic [15:0] epc, input logic etk,
                     input logic eill);
    issue(c, 1'b0, st, p, o);
    wait_done(tag, 8);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_pc"}, pc_out, epc);
    chk({tag, "_taken"}, taken, etk);
    chk({tag, "_pc_load"}, pc_load, etk);
    chk({tag, "_illegal"}, illegal, eill);
  endtask

  task automatic serve(input string tag, input logic [15:0] a,
                       input logic [7:0] d, input int w);
    int n = 0;
    while (!mem_rd_req && n < 20) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < w; i++) begin
      chk({tag, "_req_wait"}, mem_rd_req, 1'b1);
      chk({tag, "_addr_wait"}, mem_addr, a);
      @(posedge clk); #1;
    end
    chk({tag, "_addr"}, mem_addr, a);
    mem_rd_valid = 1'b1; mem_rd_data = d;
    @(posedge clk); #1;
    mem_rd_valid = 1'b0; mem_rd_data = 8'hC3;
  endtask

  function automatic logic want(input logic [7:0] c, input logic [7:0] st);
    logic n, v, z, cf;
    {n, v, z, cf} = {st[7], st[6], st[1], st[0]};
    case (c)
      8'h04: return cf == 1'b0;
      8'h05: return cf == 1'b1;
      8'h06: return z == 1'b1;
      8'h07: return n == 1'b1;
      8'h08: return z == 1'b0;
      8'h09: return n == 1'b0;
      8'h0A: return v == 1'b0;
      8'h0B: return v == 1'b1;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    logic [7:0] ops [9];
    ops = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0A, 8'h0B, 8'h1C};

    #12;
    chk("rst_ready", op_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_pc_load", pc_load, 1'b0);
    chk("rst_taken", taken, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_req", mem_rd_req, 1'b0);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_addr", mem_addr, 16'h0000);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run("bne_cross", 8'h08, 8'h00, 16'h80F0, 16'h0020,
        4, 16'h8110, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("hold_done", done, 1'b0);
    chk("hold_pc_out", pc_out, 16'h8110);

    run("beq_nt", 8'h06, 8'h00, 16'h4000, 16'h0010,
        2, 16'h4000, 1'b0, 1'b0);
    prev_acc = acc;
    run("bmi_back", 8'h07, 8'h80, 16'h1234, 16'h00FE,
        3, 16'h1232, 1'b1, 1'b0);
    chk("issue_interval", acc - prev_acc, 3);
    run("bcs_wrap", 8'h05, 8'h01, 16'hFFF0, 16'h0020,
        4, 16'h0010, 1'b1, 1'b0);
    run("jmp_abs", 8'h1C, 8'h00, 16'h5000, 16'hC0DE,
        2, 16'hC0DE, 1'b1, 1'b0);
    run("illegal", 8'h55, 8'hFF, 16'h2222, 16'h0033,
        2, 16'h2222, 1'b0, 1'b1);

    issue(8'h1C, 1'b1, 8'h00, 16'h0900, 16'h02FF);
    serve("ptr_lo", 16'h02FF, 8'h34, 3);
    serve("ptr_hi", 16'h0200, 8'h12, 3);
    wait_done("jmp_ind", 8);
    chk("jmp_ind_lat", lat, 10);
    chk("jmp_ind_pc", pc_out, 16'h1234);
    chk("jmp_ind_load", pc_load, 1'b1);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 16; k++) begin
        logic [7:0] st;
        logic       t;
        logic       jmp;
        st  = {k[3], k[2], 4'b0000, k[1], k[0]};
        t   = want(ops[i], st);
        jmp = (ops[i] == 8'h1C);
        run($sformatf("sweep_%0h_%0h", ops[i], k), ops[i], st,
            16'h1000, 16'h0004, (t && !jmp) ? 3 : 2,
            jmp ? 16'h0004 : (t ? 16'h1004 : 16'h1000), t, 1'b0);
      end
    end

    issue(8'h1C, 1'b1, 8'h00, 16'h0700, 16'h0300);
    serve("rst_lo", 16'h0300, 8'h77, 0);
    chk("rst_in_hi", mem_addr, 16'h0301);
    #2 rst = 1'b1;
    #1;
    chk("async_req", mem_rd_req, 1'b0);
    chk("async_ready", op_ready, 1'b1);
    chk("async_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rd_valid = 1'b1; mem_rd_data = 8'hAB;
    @(posedge clk); #1;
    mem_rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_done", done, 1'b0);
      chk("post_rst_ready", op_ready, 1'b1);
      @(posedge clk); #1;
    end
    run("after_rst", 8'h09, 8'h00, 16'h3000, 16'h0008,
        3, 16'h3008, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
